fetch_stage: RTL and testbench

- Fetch stage of the P7 MIPS pipeline: owns the PC register, sits directly downstream of Npcmodule and consumes its NPc.
- Drives PcF to the instruction memory and back to Npcmodule.
- Detects fetch address exceptions and holds the F/D pipeline register (PcD, InstrD, ExcCodeD, BDD) consumed by decode, Npcmodule and CP0.

---
 rtl/fetch_stage.sv | 62 ++++++
 tb/tb_fetch_stage.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, fetch AdEL detection and F/D pipeline register; FETCH_RANGE_CHECK_EN adds the IM range check
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] IM_LO      = 32'h0000_3000,
    parameter logic [31:0] IM_HI      = 32'h0000_6ffc
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] NPc,
    input  logic        Stall,
    input  logic        Req,
    input  logic        D_eret,
    input  logic        BranchD,
    input  logic [31:0] InstrIM,
    output logic [31:0] PcF,
    output logic [31:0] PcD,
    output logic [31:0] InstrD,
    output logic [4:0]  ExcCodeD,
    output logic        BDD
);
`ifdef FETCH_RANGE_CHECK_EN
    localparam logic RANGE_EN = 1'b1;
`else
    localparam logic RANGE_EN = 1'b0;
`endif
    logic        exc_f;
    logic [4:0]  exc_code_f;
    logic [31:0] instr_f;
    // flag misaligned (and optionally out-of-range) fetches and replace them with a nop
    always_comb begin
        exc_f      = (|PcF[1:0]) | (RANGE_EN & ((PcF < IM_LO) | (PcF > IM_HI)));
        exc_code_f = exc_f ? 5'd4 : 5'd0;
        instr_f    = exc_f ? 32'h0 : InstrIM;
    end
    // PC register: a request redirects even through a stall
    always_ff @(posedge clk) begin
        if (reset)
            PcF <= RESET_PC;
        else if (Req || !Stall)
            PcF <= NPc;
    end
    // F/D register: flush on request, hold on stall, kill the slot after eret
    always_ff @(posedge clk) begin
        if (reset) begin
            PcD      <= 32'h0;
            InstrD   <= 32'h0;
            ExcCodeD <= 5'd0;
            BDD      <= 1'b0;
        end else if (Req) begin
            PcD      <= HANDLER_PC;
            InstrD   <= 32'h0;
            ExcCodeD <= 5'd0;
            BDD      <= 1'b0;
        end else if (!Stall) begin
            PcD      <= PcF;
            InstrD   <= D_eret ? 32'h0 : instr_f;
            ExcCodeD <= D_eret ? 5'd0 : exc_code_f;
            BDD      <= D_eret ? 1'b0 : BranchD;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed test-plan checks plus randomized run against a behavioural model
module tb_fetch_stage;
`ifdef FETCH_RANGE_CHECK_EN
    localparam bit RANGE = 1'b1;
`else
    localparam bit RANGE = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        reset, Stall, Req, D_eret, BranchD;
    logic [31:0] NPc, InstrIM, PcF, PcD, InstrD;
    logic [4:0]  ExcCodeD;
    logic        BDD;
    int          n_cmp = 0, n_bad = 0;
    bit          chk = 1'b0;
    logic [31:0] m_pc, m_pcd, m_instr;
    logic [4:0]  m_exc;
    logic        m_bd;

    fetch_stage dut (
        .clk(clk), .reset(reset), .NPc(NPc), .Stall(Stall), .Req(Req),
        .D_eret(D_eret), .BranchD(BranchD), .InstrIM(InstrIM),
        .PcF(PcF), .PcD(PcD), .InstrD(InstrD), .ExcCodeD(ExcCodeD), .BDD(BDD)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    assign InstrIM = mem(PcF);

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit bad_addr(input logic [31:0] a);
        return (a % 4 != 0) || (RANGE && (a < 32'h3000 || a > 32'h6ffc));
    endfunction

    // the model: what each register must hold after one edge, from the behavioural rules
    task automatic model(input bit r, input logic [31:0] npc, input bit st, rq, er, br);
        logic [31:0] old;
        old = m_pc;
        if (r) begin
            m_pc = 32'h3000; m_pcd = 0; m_instr = 0; m_exc = 0; m_bd = 0;
        end else if (rq) begin
            m_pc = npc; m_pcd = 32'h4180; m_instr = 0; m_exc = 0; m_bd = 0;
        end else if (!st) begin
            m_pc  = npc;
            m_pcd = old;
            if (er) begin
                m_instr = 0; m_exc = 0; m_bd = 0;
            end else begin
                m_instr = bad_addr(old) ? 32'h0 : mem(old);
                m_exc   = bad_addr(old) ? 5'd4 : 5'd0;
                m_bd    = br;
            end
        end
    endtask

    task automatic step(input bit r, input logic [31:0] npc, input bit st = 0, rq = 0, er = 0, br = 0);
        reset = r; NPc = npc; Stall = st; Req = rq; D_eret = er; BranchD = br;
        @(posedge clk);
        model(r, npc, st, rq, er, br);
        @(negedge clk);
        #1;
    endtask

    // every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk) begin
            cmp("PcF", PcF, m_pc);
            cmp("PcD", PcD, m_pcd);
            cmp("InstrD", InstrD, m_instr);
            cmp("ExcCodeD", {27'h0, ExcCodeD}, {27'h0, m_exc});
            cmp("BDD", {31'h0, BDD}, {31'h0, m_bd});
        end
    end

    initial begin
        @(negedge clk);
        step(1, 32'h0);
        chk = 1'b1;
        cmp("rst_PcF", PcF, 32'h3000);
        cmp("rst_PcD", PcD, 32'h0);
        cmp("rst_InstrD", InstrD, 32'h0);
        cmp("rst_BDD", {31'h0, BDD}, 32'h0);
        step(0, 32'h3004);
        cmp("seq_PcF", PcF, 32'h3004);
        cmp("seq_PcD", PcD, 32'h3000);
        cmp("seq_InstrD", InstrD, mem(32'h3000));
        step(0, 32'h3008);
        step(0, 32'h300c);
        cmp("seq2_PcF", PcF, 32'h300c);
        cmp("seq2_PcD", PcD, 32'h3008);
        step(0, 32'h3010, 1);
        step(0, 32'h3010, 1);
        cmp("stall_PcF", PcF, 32'h300c);
        cmp("stall_PcD", PcD, 32'h3008);
        cmp("stall_InstrD", InstrD, mem(32'h3008));
        step(0, 32'h3010);
        cmp("unstall_PcF", PcF, 32'h3010);
        step(0, 32'h3001);
        cmp("mis_PcF", PcF, 32'h3001);
        step(0, 32'h3005);
        cmp("mis_PcD", PcD, 32'h3001);
        cmp("mis_InstrD", InstrD, 32'h0);
        cmp("mis_Exc", {27'h0, ExcCodeD}, 32'd4);
        step(0, 32'h7000);
        step(0, 32'h7004, 0, 0, 0, 1);
        cmp("rng_Exc", {27'h0, ExcCodeD}, RANGE ? 32'd4 : 32'd0);
        cmp("rng_InstrD", InstrD, RANGE ? 32'h0 : mem(32'h7000));
        cmp("br_BDD", {31'h0, BDD}, 32'd1);
        step(0, 32'h4180, 1, 1);
        cmp("req_PcF", PcF, 32'h4180);
        cmp("req_PcD", PcD, 32'h4180);
        cmp("req_InstrD", InstrD, 32'h0);
        cmp("req_BDD", {31'h0, BDD}, 32'd0);
        step(0, 32'h3020);
        step(0, 32'h3024, 0, 0, 1, 1);
        cmp("eret_PcD", PcD, 32'h3020);
        cmp("eret_InstrD", InstrD, 32'h0);
        cmp("eret_BDD", {31'h0, BDD}, 32'd0);
        step(0, 32'h3028, 1, 0, 1);
        cmp("eret_st_PcF", PcF, 32'h3024);
        cmp("eret_st_PcD", PcD, 32'h3020);
        step(0, 32'h3028, 0, 0, 1);
        cmp("eret_go_PcD", PcD, 32'h3024);
        cmp("eret_go_InstrD", InstrD, 32'h0);
        cmp("eret_go_PcF", PcF, 32'h3028);
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] npc;
            int sel;
            sel = $urandom_range(0, 15);
            npc = sel < 10 ? m_pc + 4 :
                  sel < 12 ? 32'h3000 + ($urandom_range(0, 32'h3fff) & ~32'h3) :
                  sel < 14 ? m_pc + $urandom_range(1, 3) : $urandom;
            step($urandom_range(0, 63) == 0, npc, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0);
        end
        chk = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
